multiword_add_sequencer: RTL and testbench

- Controller that time-multiplexes one external 32-bit carry-select adder to perform WORDS×32-bit add/subtract.
- Operands stream in least-significant word first over a valid/ready handshake. The controller drives the adder's a/b/carry_in and chains carry_out between words through a register.
- Result words stream out over a second valid/ready handshake. The block sits between the ALU issue logic and the shared adder.

---
 rtl/multiword_add_sequencer_if.sv | 29 ++
 rtl/multiword_add_sequencer.sv | 155 +++++++++++++++
 tb/tb_multiword_add_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/multiword_add_sequencer_if.sv
// Operand, adder and result bundle for multiword_add_sequencer.
// slave: the sequencer's side; master: the issue logic, shared adder and result consumer.
interface multiword_add_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_word;
    logic [31:0] b_word;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum_word;
    logic        out_last;
    logic        carry_out;
    logic        overflow;

    modport slave (
        input  in_valid, a_word, b_word, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, sum_word, out_last, carry_out, overflow
    );

    modport master (
        output in_valid, a_word, b_word, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, sum_word, out_last, carry_out, overflow
    );
endinterface

// File: rtl/multiword_add_sequencer.sv
// WORDS x 32-bit add/subtract sequenced LSW-first through one shared external 32-bit adder.
// Define MWADD_OVF_EN to build the signed-overflow flag; otherwise overflow is tied to 0.
module multiword_add_sequencer #(
    parameter int unsigned WORDS = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start_i,
    input  logic                       sub_i,
    output logic                       busy_o,
    output logic                       done_o,
    multiword_add_sequencer_if.slave   bus_io
);

    localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               sub_q, sub_d;
    logic [31:0]        sum_q, sum_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               cout_q, cout_d;
    logic               done_q, done_d;

    logic               in_ready;
    logic               accept;
    logic               last_word;
    logic               out_hs;
    logic               start_acc;
    logic [31:0]        add_b;

    // Subtraction is a + ~b + 1: the +1 is the initial carry loaded with sub.
    assign add_b     = sub_q ? ~bus_io.b_word : bus_io.b_word;
    // One-entry output register: accept only if it is empty or draining this cycle.
    assign in_ready  = (state_q == StRun) && (!out_valid_q || bus_io.out_ready);
    assign accept    = bus_io.in_valid && in_ready;
    assign last_word = (cnt_q == LastCnt);
    assign out_hs    = out_valid_q && bus_io.out_ready;
    assign start_acc = (state_q == StIdle) && start_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        sub_d       = sub_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        cout_d      = cout_q;
        done_d      = 1'b0;

        if (out_hs) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    sub_d   = sub_i;
                    carry_d = sub_i;
                    cnt_d   = '0;
                    cout_d  = 1'b0;
                end
            end
            StRun: begin
                if (accept) begin
                    sum_d       = bus_io.add_sum;
                    out_valid_d = 1'b1;
                    carry_d     = bus_io.add_cout;
                    cnt_d       = cnt_q + CNT_W'(1);
                    out_last_d  = last_word;
                    if (last_word) begin
                        cout_d  = bus_io.add_cout;
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (out_hs && out_last_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            cout_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            sub_q       <= sub_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            cout_q      <= cout_d;
            done_q      <= done_d;
        end
    end

`ifdef MWADD_OVF_EN
    logic ovf_q, ovf_d;

    // Sign of the top word decides overflow for the whole multiword result.
    always_comb begin
        ovf_d = ovf_q;
        if (start_acc) begin
            ovf_d = 1'b0;
        end else if (accept && last_word) begin
            ovf_d = (bus_io.a_word[31] == add_b[31]) && (bus_io.add_sum[31] != bus_io.a_word[31]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus_io.overflow = ovf_q;
`else
    assign bus_io.overflow = 1'b0;
`endif

    assign busy_o           = (state_q != StIdle);
    assign done_o           = done_q;
    assign bus_io.in_ready  = in_ready;
    assign bus_io.add_a     = bus_io.a_word;
    assign bus_io.add_b     = add_b;
    assign bus_io.add_cin   = carry_q;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.sum_word  = sum_q;
    assign bus_io.out_last  = out_last_q;
    assign bus_io.carry_out = cout_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer (WORDS=4): directed table, random ops vs a
// 128-bit arithmetic model, plus reset-mid-op and start-while-busy sequences.
module tb_multiword_add_sequencer;

    localparam int WORDS = 4;
`ifdef MWADD_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start_i = 1'b0;
    logic sub_i = 1'b0;
    logic busy_o, done_o;

    int vectors = 0;
    int miscompares = 0;

    multiword_add_sequencer_if bus ();

    multiword_add_sequencer #(.WORDS(WORDS)) dut (
        .clock   (clock),
        .reset   (reset),
        .start_i (start_i),
        .sub_i   (sub_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bus_io  (bus)
    );

    // The shared external adder.
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'd0, bus.add_cin};

    always #5 clock = ~clock;

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic         sub;
        int           bp;
        logic [127:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain 129-bit arithmetic on the whole operands.
    function automatic logic [129:0] model(input logic [127:0] a, input logic [127:0] b,
                                           input logic s);
        logic [127:0] bb;
        logic [128:0] r;
        logic         ovf;
        bb  = s ? ~b : b;
        r   = {1'b0, a} + {1'b0, bb} + {128'd0, s};
        ovf = OVF_ON && (a[127] == bb[127]) && (r[127] != a[127]);
        return {ovf, r[128], r[127:0]};
    endfunction

    // bp: 0 = out_ready high, 1 = random valid/ready, 2 = out_ready low 3 cycles after word 1.
    task automatic run_op(input logic [127:0] a, input logic [127:0] b, input logic s,
                          input int bp, input bit poke,
                          output logic [127:0] got, output logic got_cout, output logic got_ovf,
                          output int nlast);
        int  wi, ri, cyc, hold;
        bit  fin, stalled;
        logic [31:0] stall_sum;
        wi = 0; ri = 0; cyc = 0; hold = 0; fin = 0; stalled = 0; stall_sum = '0;
        got = '0; got_cout = 1'bx; got_ovf = 1'bx; nlast = 0;

        start_i = 1'b1;
        sub_i = s;
        bus.in_valid = 1'b1;
        bus.a_word = a[31:0];
        bus.b_word = b[31:0];
        bus.out_ready = 1'b1;
        #1;
        chk("in_ready_idle", {127'd0, bus.in_ready}, 128'd0);
        @(posedge clock);
        @(negedge clock);
        start_i = 1'b0;
        chk("busy_after_start", {127'd0, busy_o}, 128'd1);

        while (!fin && cyc < 200) begin
            if (poke && wi == 1) begin
                start_i = 1'b1;
                sub_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            bus.in_valid = (wi < WORDS) && (bp != 1 || $urandom_range(0, 3) != 0);
            bus.a_word = (wi < WORDS) ? a[32*wi +: 32] : 32'd0;
            bus.b_word = (wi < WORDS) ? b[32*wi +: 32] : 32'd0;
            if (bp == 1) begin
                bus.out_ready = ($urandom_range(0, 2) != 0);
            end else if (bp == 2 && ri == 1 && hold < 3) begin
                bus.out_ready = 1'b0;
                hold++;
            end else begin
                bus.out_ready = 1'b1;
            end
            #1;
            if (stalled) begin
                chk("stall_valid", {127'd0, bus.out_valid}, 128'd1);
                chk("stall_sum", {96'd0, bus.sum_word}, {96'd0, stall_sum});
            end
            stalled = bus.out_valid && !bus.out_ready;
            stall_sum = bus.sum_word;
            if (stalled) chk("stall_in_ready", {127'd0, bus.in_ready}, 128'd0);
            if (bus.out_valid && bus.out_ready) begin
                if (ri < WORDS) got[32*ri +: 32] = bus.sum_word;
                chk("out_last_pos", {127'd0, bus.out_last}, {127'd0, ri == WORDS - 1});
                if (bus.out_last) begin
                    nlast++;
                    got_cout = bus.carry_out;
                    got_ovf = bus.overflow;
                    fin = 1;
                end
                ri++;
            end
            if (bus.in_valid && bus.in_ready) wi++;
            @(posedge clock);
            @(negedge clock);
            cyc++;
        end
        start_i = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("op_finished", {127'd0, fin}, 128'd1);
        chk("done_pulse", {127'd0, done_o}, 128'd1);
        chk("idle_after", {127'd0, busy_o}, 128'd0);
        chk("result_words", 128'(ri), 128'(WORDS));
        @(negedge clock);
        chk("done_one_cycle", {127'd0, done_o}, 128'd0);
        chk("no_extra_word", {127'd0, bus.out_valid}, 128'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, {127'd0, busy_o}, 128'd0);
        chk({tag, "_in_ready"}, {127'd0, bus.in_ready}, 128'd0);
        chk({tag, "_out_valid"}, {127'd0, bus.out_valid}, 128'd0);
        chk({tag, "_out_last"}, {127'd0, bus.out_last}, 128'd0);
        chk({tag, "_carry_out"}, {127'd0, bus.carry_out}, 128'd0);
        chk({tag, "_overflow"}, {127'd0, bus.overflow}, 128'd0);
        chk({tag, "_done"}, {127'd0, done_o}, 128'd0);
        chk({tag, "_sum_word"}, {96'd0, bus.sum_word}, 128'd0);
    endtask

    initial begin
        vec_t         tbl[5];
        logic [127:0] got, ra, rb;
        logic         gc, gv, rs;
        logic [129:0] m;
        int           nl;

        tbl[0] = '{128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0, 0,
                   128'h00000001_00000000_00000000_00000000, 1'b0, 1'b0};
        tbl[1] = '{128'h0, 128'h1, 1'b1, 0,
                   128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b0, 1'b0};
        tbl[2] = '{128'h5, 128'h3, 1'b1, 0, 128'h2, 1'b1, 1'b0};
        tbl[3] = '{128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0, 0,
                   128'h80000000_00000000_00000000_00000000, 1'b0, OVF_ON};
        tbl[4] = '{128'h12345678_9ABCDEF0_FFFFFFFF_80000000,
                   128'h0FEDCBA9_87654321_00000001_80000000, 1'b0, 2,
                   128'h22222222_22222212_00000001_00000000, 1'b0, 1'b0};

        bus.in_valid = 1'b0;
        bus.a_word = '0;
        bus.b_word = '0;
        bus.out_ready = 1'b1;
        #1;
        chk_zero_outputs("reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk_zero_outputs("post_reset");

        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].bp, 1'b0, got, gc, gv, nl);
            chk($sformatf("tbl%0d_sum", i), got, tbl[i].exp_sum);
            chk($sformatf("tbl%0d_cout", i), {127'd0, gc}, {127'd0, tbl[i].exp_cout});
            chk($sformatf("tbl%0d_ovf", i), {127'd0, gv}, {127'd0, tbl[i].exp_ovf});
            chk($sformatf("tbl%0d_nlast", i), 128'(nl), 128'd1);
        end

        // Start pulsed with sub=1 mid-run must be ignored.
        run_op(128'h1_00000000_00000007, 128'h5, 1'b0, 0, 1'b1, got, gc, gv, nl);
        chk("poke_sum", got, 128'h1_00000000_0000000C);
        chk("poke_cout", {127'd0, gc}, 128'd0);

        // Reset mid-op after two words accepted.
        start_i = 1'b1;
        sub_i = 1'b0;
        @(negedge clock);
        start_i = 1'b0;
        bus.in_valid = 1'b1;
        bus.a_word = 32'hFFFFFFFF;
        bus.b_word = 32'h1;
        @(negedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk_zero_outputs("mid_reset");
        @(negedge clock);
        reset = 1'b0;
        run_op(128'h1, 128'h1, 1'b0, 0, 1'b0, got, gc, gv, nl);
        chk("after_reset_sum", got, 128'h2);
        chk("after_reset_cout", {127'd0, gc}, 128'd0);

        for (int k = 0; k < 24; k++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            if (k % 6 == 0) ra[127] = ~rb[127];
            rs = 1'($urandom_range(0, 1));
            m = model(ra, rb, rs);
            run_op(ra, rb, rs, 1, 1'b0, got, gc, gv, nl);
            chk($sformatf("rnd%0d_sum", k), got, m[127:0]);
            chk($sformatf("rnd%0d_cout", k), {127'd0, gc}, {127'd0, m[128]});
            chk($sformatf("rnd%0d_ovf", k), {127'd0, gv}, {127'd0, m[129]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
